// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - RV64 funct3 values for loads and stores
//   - format codes driven towards data memory
//   - response error codes
//   - FSM state type and small decode helpers
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings (funct3[2] must be 0)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Format codes understood by data memory
  localparam logic [2:0] LOAD_FMT_BYTE   = 3'b000;
  localparam logic [2:0] LOAD_FMT_HALF   = 3'b001;
  localparam logic [2:0] LOAD_FMT_WORD   = 3'b010;
  localparam logic [2:0] LOAD_FMT_DOUBLE = 3'b101;

  localparam logic [1:0] STORE_FMT_BYTE   = 2'b00;
  localparam logic [1:0] STORE_FMT_HALF   = 2'b01;
  localparam logic [1:0] STORE_FMT_WORD   = 2'b10;
  localparam logic [1:0] STORE_FMT_DOUBLE = 2'b11;

  // Response error codes
  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_FAULT      = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  // Size field (funct3[1:0]) -> memory load format code
  function automatic logic [2:0] load_fmt(input logic [1:0] sz);
    case (sz)
      2'b00:   return LOAD_FMT_BYTE;
      2'b01:   return LOAD_FMT_HALF;
      2'b10:   return LOAD_FMT_WORD;
      default: return LOAD_FMT_DOUBLE;
    endcase
  endfunction

  // Size field -> mask of address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sign/zero extension of raw load data.
// Ports:
//   funct3_i    - load funct3; [1:0] selects size, [2] selects zero-extension
//   mem_rdata_i - raw data from memory, valid bytes in the LSBs
//   rdata_o     - 64-bit extended result
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] mem_rdata_i,
  output logic [63:0] rdata_o
);

  logic zext;
  assign zext = funct3_i[2];

  always_comb begin
    rdata_o = mem_rdata_i;
    unique case (funct3_i[1:0])
      2'b00: rdata_o = zext ? {56'd0, mem_rdata_i[7:0]}
                            : {{56{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      2'b01: rdata_o = zext ? {48'd0, mem_rdata_i[15:0]}
                            : {{48{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      2'b10: rdata_o = zext ? {32'd0, mem_rdata_i[31:0]}
                            : {{32{mem_rdata_i[31]}}, mem_rdata_i[31:0]};
      2'b11: rdata_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-addressed data-memory port.
// Accepts one load/store per request handshake, checks it (illegal funct3,
// misalignment, out-of-range), drives the memory for exactly one ACCESS cycle,
// and returns an extended load value or error code on the response handshake.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_we, req_funct3            - store select and RV64 funct3
//   req_addr, req_wdata           - byte address and store data
//   rsp_valid/rsp_ready           - response handshake, held until accepted
//   rsp_rdata, rsp_err            - extended load data and error code
//   mem_addr, mem_wdata           - memory address and store data
//   mem_rdata                     - combinational memory read data
//   mem_write_en, mem_read_en     - one-cycle strobes
//   load_format, store_format     - access size codes for memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  load_format,
  output logic [1:0]  store_format
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rsp_rdata_q;
  logic [1:0]  rsp_err_q;

  // ---------------- request checks (on the live request, used at accept) ----
  logic [3:0]  req_size;
  logic [64:0] req_end;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_fault;
  logic [1:0]  req_err;
  logic        accept;

  assign req_size = 4'd1 << req_funct3[1:0];
  // One extra bit so an address near 2^64 cannot wrap back into range.
  assign req_end  = {1'b0, req_addr} + {61'd0, req_size};

  assign req_illegal    = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
  assign req_misaligned = CHECK_ALIGN && ((req_addr[2:0] & align_mask(req_funct3[1:0])) != 3'b000);
  assign req_fault      = req_end > 65'(MEM_BYTES);

  always_comb begin
    req_err = ERR_OK;
    if (req_illegal)         req_err = ERR_ILLEGAL;
    else if (req_misaligned) req_err = ERR_MISALIGNED;
    else if (req_fault)      req_err = ERR_FAULT;
  end

  assign accept = (state_q == IDLE) && req_valid;

  // ---------------- load extension ----------------
  logic [63:0] ext_rdata;

  load_extend u_load_extend (
    .funct3_i    (funct3_q),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (ext_rdata)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = (req_err == ERR_OK) ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= ERR_OK;
    end else begin
      if (accept) begin
        we_q        <= req_we;
        funct3_q    <= req_funct3;
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        rsp_rdata_q <= 64'd0;
        rsp_err_q   <= req_err;
      end else if (state_q == ACCESS) begin
        // Memory read is combinational, so the extended value is ready by this edge.
        rsp_rdata_q <= we_q ? 64'd0 : ext_rdata;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_rdata_q <= 64'd0;
        rsp_err_q   <= ERR_OK;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  // Memory-side outputs depend only on state_q; since reset clears state_q
  // asynchronously, asserting rst_n during ACCESS drops the strobes at once.
  always_comb begin
    req_ready    = (state_q == IDLE);
    rsp_valid    = (state_q == RESP);
    rsp_rdata    = rsp_rdata_q;
    rsp_err      = rsp_err_q;
    mem_addr     = 64'd0;
    mem_wdata    = 64'd0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    load_format  = 3'b000;
    store_format = 2'b00;
    if (state_q == ACCESS) begin
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      mem_write_en = we_q;
      mem_read_en  = !we_q;
      load_format  = load_fmt(funct3_q[1:0]);
      store_format = funct3_q[1:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit paired with a simple byte-array data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [2:0]  load_format;
  logic [1:0]  store_format;

  load_store_unit #(.MEM_BYTES(4096), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .load_format(load_format), .store_format(store_format)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- data memory (combinational read, write at edge) ----------------
  logic [7:0] tb_mem [4096];

  always_comb begin
    int n;
    mem_rdata = 64'd0;
    case (load_format)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b010:  n = 4;
      3'b101:  n = 8;
      default: n = 0;
    endcase
    for (int i = 0; i < 8; i++)
      if (i < n && mem_addr < 64'(4096 - i))
        mem_rdata[8*i +: 8] = tb_mem[mem_addr[11:0] + 12'(i)];
  end

  always @(posedge clk) begin
    if (mem_write_en)
      for (int i = 0; i < 8; i++)
        if (i < (1 << store_format) && mem_addr < 64'(4096 - i))
          tb_mem[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [4096];

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [63:0] addr;
    bit [63:0] wdata;
    bit [63:0] rdata;
    bit [1:0]  err;
    int        acc_cyc;
    int        strobes;
    bit        seen;
  } exp_t;
  exp_t q[$];

  // Architectural outcome of a request, from the access rules alone.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [63:0] addr,
                                output bit [63:0] rd, output bit [1:0] err);
    int n;
    bit [64:0] last;
    bit [63:0] v;
    n = 1 << f3[1:0];
    last = {1'b0, addr} + 65'(n);
    if ((!we && f3 == 3'b111) || (we && f3[2])) err = 2'd3;
    else if ((addr % 64'(n)) != 0)               err = 2'd1;
    else if (last > 65'd4096)                    err = 2'd2;
    else                                         err = 2'd0;
    rd = 64'd0;
    if (err == 2'd0 && !we) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v |= 64'(ref_mem[int'(addr) + i]) << (8*i);
      if (!f3[2] && n < 8 && v[8*n-1]) v |= ~64'd0 << (8*n);
      rd = v;
    end
  endfunction

  logic [63:0] last_rdata = 64'd0;
  logic [1:0]  last_err = 2'd0;
  bit          expect_idle = 1'b0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      expect_idle = 1'b0;
    end else begin
      check("strobe_exclusive", 64'(mem_read_en & mem_write_en), 64'd0);
      if (expect_idle) begin
        check("ready_after_resp", 64'(req_ready), 64'd1);
        expect_idle = 1'b0;
      end
      if (!mem_read_en && !mem_write_en) check("mem_addr_idle", mem_addr, 64'd0);
      if (q.size() > 0) begin
        if (mem_read_en || mem_write_en) begin
          q[0].strobes++;
          check("mem_addr", mem_addr, q[0].addr);
          check("mem_write_sel", 64'(mem_write_en), 64'(q[0].we));
          check("strobe_cycle", 64'(cycle - q[0].acc_cyc), 64'd1);
        end
        if (rsp_valid) begin
          if (!q[0].seen) begin
            check("rsp_latency", 64'(cycle - q[0].acc_cyc), (q[0].err != 0) ? 64'd1 : 64'd2);
            q[0].seen = 1'b1;
          end
          check("rsp_rdata", rsp_rdata, q[0].rdata);
          check("rsp_err", 64'(rsp_err), 64'(q[0].err));
          check("req_ready_busy", 64'(req_ready), 64'd0);
          if (rsp_ready) begin
            check("strobe_count", 64'(q[0].strobes), (q[0].err == 0) ? 64'd1 : 64'd0);
            if (q[0].we && q[0].err == 0)
              for (int i = 0; i < (1 << q[0].f3[1:0]); i++)
                ref_mem[int'(q[0].addr) + i] = q[0].wdata[8*i +: 8];
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(q.pop_front());
            expect_idle = 1'b1;
          end
        end
      end else begin
        check("no_spurious_rsp", 64'(rsp_valid), 64'd0);
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.we = req_we; e.f3 = req_funct3; e.addr = req_addr; e.wdata = req_wdata;
        model(req_we, req_funct3, req_addr, e.rdata, e.err);
        e.acc_cyc = cycle; e.strobes = 0; e.seen = 1'b0;
        q.push_back(e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [63:0] addr,
                        input bit [63:0] wdata, input int hold);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin tests++; fails++; $display("FAIL req_ready_timeout: got 0 expected 1"); end
    @(posedge clk); #1;
    // Scramble the request after accept; it must have no effect.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_funct3 = ~f3;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin tests++; fails++; $display("FAIL rsp_valid_timeout: got 0 expected 1"); end
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string name, input bit we, input bit [2:0] f3, input bit [63:0] addr,
                     input bit [63:0] wdata, input bit [63:0] exp_rd, input bit [1:0] exp_err,
                     input int hold);
    do_req(we, f3, addr, wdata, hold);
    check({name, "_rdata"}, last_rdata, exp_rd);
    check({name, "_err"}, 64'(last_err), 64'(exp_err));
    $display("[TB] %s we=%0d f3=%0d addr=0x%0h -> rdata=0x%0h err=%0d", name, we, f3, addr,
             last_rdata, last_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin tb_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mem_en", 64'({mem_read_en, mem_write_en}), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_formats", 64'({load_format, store_format}), 64'd0);
    rst_n = 1'b1;
    #1 check("rst_req_ready", 64'(req_ready), 64'd1);

    run("sd_10",   1, 3'b011, 64'h10, 64'h8877665544332211, 64'h0, 2'd0, 0);
    run("ld_10",   0, 3'b011, 64'h10, 64'h0, 64'h8877665544332211, 2'd0, 0);
    run("lb_17",   0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 2'd0, 0);
    run("lbu_17",  0, 3'b100, 64'h17, 64'h0, 64'h88, 2'd0, 0);
    run("lh_16",   0, 3'b001, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 2'd0, 0);
    run("lwu_14",  0, 3'b110, 64'h14, 64'h0, 64'h88776655, 2'd0, 0);
    run("lw_14",   0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 2'd0, 0);
    run("lhu_10",  0, 3'b101, 64'h10, 64'h0, 64'h2211, 2'd0, 0);
    run("lb_10",   0, 3'b000, 64'h10, 64'h0, 64'h11, 2'd0, 0);
    run("lw_12",   0, 3'b010, 64'h12, 64'h0, 64'h0, 2'd1, 0);
    run("sd_ff8",  1, 3'b011, 64'hFF8, 64'h0123456789ABCDEF, 64'h0, 2'd0, 0);
    run("ld_ff8h", 0, 3'b011, 64'hFF8, 64'h0, 64'h0123456789ABCDEF, 2'd0, 5);
    run("sd_ffc",  1, 3'b011, 64'hFFC, 64'h1, 64'h0, 2'd1, 0);
    run("sd_1000", 1, 3'b011, 64'h1000, 64'h1, 64'h0, 2'd2, 0);
    run("ld_wrap", 0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 2'd2, 0);
    run("ld_f3_7", 0, 3'b111, 64'h10, 64'h0, 64'h0, 2'd3, 0);
    run("st_f3_4", 1, 3'b100, 64'h10, 64'h5, 64'h0, 2'd3, 0);
    run("ill_mis", 0, 3'b111, 64'h13, 64'h0, 64'h0, 2'd3, 0);
    run("lh_fff",  0, 3'b001, 64'hFFF, 64'h0, 64'h0, 2'd1, 0);
    run("lb_fff",  0, 3'b000, 64'hFFF, 64'h0, 64'h01, 2'd0, 0);
    run("lbu_1k",  0, 3'b100, 64'h1000, 64'h0, 64'h0, 2'd2, 0);
    run("sb_11",   1, 3'b000, 64'h11, 64'hFFFFFFFFFFFFFF99, 64'h0, 2'd0, 0);
    run("ld_10b",  0, 3'b011, 64'h10, 64'h0, 64'h8877665544339911, 2'd0, 0);
    run("sh_12",   1, 3'b001, 64'h12, 64'h000000000000ABCD, 64'h0, 2'd0, 0);
    run("lw_10",   0, 3'b010, 64'h10, 64'h0, 64'hFFFFFFFFABCD9911, 2'd0, 0);

    // Reset in the middle of a store ACCESS must keep old data in memory.
    run("sd_20",   1, 3'b011, 64'h20, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 2'd0, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h20;
    req_wdata = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_we_pre", 64'(mem_write_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_drop", 64'(mem_write_en), 64'd0);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("rst_mid_ready", 64'(req_ready), 64'd1);
    $display("[TB] reset during store ACCESS at addr 0x20");
    run("ld_20",   0, 3'b011, 64'h20, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
